alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter that shares a single instance of the 64-bit `alu` datapath between the integer execute stage (requester 0) and the address/CSR helper unit (requester 1). Each requester has a valid/ready request channel. Results return on one registered response channel, tagged with the requester id, with one-cycle latency and backpressure. Default arbitration is round-robin.

## Interface
Parameters:
- none; data width is fixed at 64 to match `alu`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid & ready.
- `reqN_op`  in  5  ALU op code, passed to `alu.op_in`.
- `reqN_sub_sra`  in  1  subtract/arithmetic-shift select.
- `reqN_src1` / `reqN_src2`  in  3  operand source selects.
- `reqN_pc`, `reqN_rs1`, `reqN_rs2`, `reqN_imm`  in  64 each  operand values.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer takes the response when valid & ready.
- `rsp_id`  out  1  requester that issued the result (0 or 1).
- `rsp_result`  out  64  registered `alu.result_out`.
- `rsp_non_zero`  out  1  registered `alu.non_zero_out`.

(`reqN_*` means one port per requester, N = 0, 1.)

## Operation
- State:
  - `prio`, 1 bit: preferred requester.
  - Response register: `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_non_zero`.
- `slot_free = !rsp_valid | rsp_ready`.
- Grant (combinational):
  - Only one requester valid: that requester gets the grant.
  - Both valid: requester `prio` gets the grant.
  - Neither valid: no grant.
- `reqN_ready = grant==N & slot_free`. At most one accept per cycle. The ready of a non-granted requester is 0.
- The mux feeds the granted requester's fields into `alu`. When there is no grant, the mux drives requester 0's fields; the output is ignored.
- On accept:
  - Response register loads the `alu` outputs and sets `rsp_id` to the granted requester.
  - `rsp_valid` is set to 1.
  - `prio` is set to the other requester.
- Drain without accept: `rsp_valid` clears to 0.
- Drain and accept in the same cycle: the register reloads and `rsp_valid` stays 1, giving full throughput.
- `rsp_*` stays stable while `rsp_valid & !rsp_ready`.
- Requester rules:
  - Once valid is raised, it stays high and all `reqN_*` fields stay stable until accepted.
  - A requester may drop valid only after its accept.
- `prio` changes only on accept. An idle or stalled cycle leaves `prio` unchanged.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_non_zero`=0, `prio`=0.
  - `req0_ready`=`req1_ready`=0 unless the corresponding valid is high. Readies are combinational from valid and state.
- Reset asserted mid-operation discards the pending response. A requester that was not accepted must re-present its request after reset.
- Latency: accept at edge N; the response is visible from edge N (cycle N+1) onward.
- Throughput: one operation per cycle while `rsp_ready`=1.
- Combinational paths:
  - `reqN_valid` → `reqM_ready`.
  - `rsp_ready` → `reqN_ready`.
  - No combinational path from any request to `rsp_*`.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins when both are valid. `prio` is removed, or tied to 0.
  - Undefined (default): round-robin as described in Operation.

## Structure
- Shared package/header `alu_pkg` holds:
  - ALU op codes (ADD_SUB, XOR, OR, AND, SLL, SRL_SRA, SLT, SLTU).
  - src1 selects (REG/PC/ZERO) and src2 selects (REG/IMM/FOUR).
  - Requester id constants `ALU_REQ_EXEC`=0 and `ALU_REQ_AUX`=1.
- One sub-module: `alu`, instantiated once. It is the datapath being shared.
- The arbiter contains only the grant logic, the operand mux, `prio`, and the response register.

## Test plan
- Reset, then req0 issues ADD with src1=REG/src2=REG, rs1=5, rs2=7, and `rsp_ready`=1.
  - `req0_ready`=1 in the issue cycle.
  - Next cycle: `rsp_valid`=1, `rsp_id`=0, `rsp_result`=12, `rsp_non_zero`=1.
- Both requesters valid continuously for 4 cycles. req0 issues XOR of 0xFF^0xFF; req1 issues SUB of 3−1.
  - Grants alternate 0,1,0,1.
  - Results alternate: 0 with `non_zero`=0, then 2 with `non_zero`=1.
- Response stalled: `rsp_ready`=0 with a response pending and req1 valid.
  - `req1_ready`=0.
  - `rsp_*` is held for 3 cycles.
  - `rsp_ready`=1 drains the response and accepts req1 in the same cycle; `rsp_valid` stays 1.
- Only req1 valid, with `prio`=0.
  - req1 is accepted immediately.
  - `prio` becomes 0.
  - `rsp_id`=1.
- `rst_n` pulsed low while `rsp_valid`=1: all outputs are 0 immediately, without waiting for a clock edge.
- With `ALU_ARB_FIXED_PRIO_EN` defined and both requesters valid for 3 cycles:
  - req0 is granted every cycle.
  - `req1_ready` stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, operand source selects, requester ids, request bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_W = 64;

  typedef enum logic [4:0] {
    ALU_OP_ADD_SUB = 5'd0,
    ALU_OP_XOR     = 5'd1,
    ALU_OP_OR      = 5'd2,
    ALU_OP_AND     = 5'd3,
    ALU_OP_SLL     = 5'd4,
    ALU_OP_SRL_SRA = 5'd5,
    ALU_OP_SLT     = 5'd6,
    ALU_OP_SLTU    = 5'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_SRC1_REG  = 3'd0,
    ALU_SRC1_PC   = 3'd1,
    ALU_SRC1_ZERO = 3'd2
  } alu_src1_e;

  typedef enum logic [2:0] {
    ALU_SRC2_REG  = 3'd0,
    ALU_SRC2_IMM  = 3'd1,
    ALU_SRC2_FOUR = 3'd2
  } alu_src2_e;

  localparam logic ALU_REQ_EXEC = 1'b0;
  localparam logic ALU_REQ_AUX  = 1'b1;

  // One requester's complete ALU operation, as carried through the operand mux.
  typedef struct packed {
    logic [4:0]       op;
    logic             sub_sra;
    logic [2:0]       src1;
    logic [2:0]       src2;
    logic [ALU_W-1:0] pc;
    logic [ALU_W-1:0] rs1;
    logic [ALU_W-1:0] rs2;
    logic [ALU_W-1:0] imm;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// 64-bit integer ALU: operand select, arithmetic/logic/shift/compare, zero detect.
// Latency: purely combinational.
// Backpressure: none; the caller registers the outputs.
module alu
  import alu_pkg::*;
(
  input  logic [4:0]       op_in,
  input  logic             sub_sra_in,
  input  logic [2:0]       src1_in,
  input  logic [2:0]       src2_in,
  input  logic [ALU_W-1:0] pc_in,
  input  logic [ALU_W-1:0] rs1_in,
  input  logic [ALU_W-1:0] rs2_in,
  input  logic [ALU_W-1:0] imm_in,
  output logic [ALU_W-1:0] result_out,
  output logic             non_zero_out
);

  logic [ALU_W-1:0] op1;
  logic [ALU_W-1:0] op2;
  logic [ALU_W-1:0] sra_res;
  logic [5:0]       shamt;

  // Operand selection; unknown select codes fall back to the register value.
  always_comb begin
    op1 = rs1_in;
    op2 = rs2_in;
    case (src1_in)
      ALU_SRC1_REG:  op1 = rs1_in;
      ALU_SRC1_PC:   op1 = pc_in;
      ALU_SRC1_ZERO: op1 = '0;
      default:       op1 = rs1_in;
    endcase
    case (src2_in)
      ALU_SRC2_REG:  op2 = rs2_in;
      ALU_SRC2_IMM:  op2 = imm_in;
      ALU_SRC2_FOUR: op2 = 64'd4;
      default:       op2 = rs2_in;
    endcase
  end

  assign shamt = op2[5:0];

  // Kept separate so the arithmetic shift is evaluated in a signed context.
  assign sra_res = $signed(op1) >>> shamt;

  // Operation decode; undefined op codes produce zero.
  always_comb begin
    result_out = '0;
    case (op_in)
      ALU_OP_ADD_SUB: result_out = sub_sra_in ? (op1 - op2) : (op1 + op2);
      ALU_OP_XOR:     result_out = op1 ^ op2;
      ALU_OP_OR:      result_out = op1 | op2;
      ALU_OP_AND:     result_out = op1 & op2;
      ALU_OP_SLL:     result_out = op1 << shamt;
      ALU_OP_SRL_SRA: result_out = sub_sra_in ? sra_res : (op1 >> shamt);
      ALU_OP_SLT:     result_out = {63'd0, $signed(op1) < $signed(op2)};
      ALU_OP_SLTU:    result_out = {63'd0, op1 < op2};
      default:        result_out = '0;
    endcase
  end

  assign non_zero_out = |result_out;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between execute (req0) and aux (req1); round-robin, or fixed req0 priority with ALU_ARB_FIXED_PRIO_EN.
// Latency: result registered, visible the cycle after accept; one op per cycle sustained.
// Backpressure: a request is accepted only when the response register is empty or draining this cycle.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_op,
  input  logic             req0_sub_sra,
  input  logic [2:0]       req0_src1,
  input  logic [2:0]       req0_src2,
  input  logic [ALU_W-1:0] req0_pc,
  input  logic [ALU_W-1:0] req0_rs1,
  input  logic [ALU_W-1:0] req0_rs2,
  input  logic [ALU_W-1:0] req0_imm,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_op,
  input  logic             req1_sub_sra,
  input  logic [2:0]       req1_src1,
  input  logic [2:0]       req1_src2,
  input  logic [ALU_W-1:0] req1_pc,
  input  logic [ALU_W-1:0] req1_rs1,
  input  logic [ALU_W-1:0] req1_rs2,
  input  logic [ALU_W-1:0] req1_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [ALU_W-1:0] rsp_result,
  output logic             rsp_non_zero
);

  alu_req_t         r0;
  alu_req_t         r1;
  alu_req_t         sel;
  logic             prio;
  logic             grant_vld;
  logic             grant_id;
  logic             slot_free;
  logic             accept;
  logic [ALU_W-1:0] alu_result;
  logic             alu_non_zero;

  assign r0 = '{op: req0_op, sub_sra: req0_sub_sra, src1: req0_src1, src2: req0_src2,
                pc: req0_pc, rs1: req0_rs1, rs2: req0_rs2, imm: req0_imm};
  assign r1 = '{op: req1_op, sub_sra: req1_sub_sra, src1: req1_src1, src2: req1_src2,
                pc: req1_pc, rs1: req1_rs1, rs2: req1_rs2, imm: req1_imm};

  // Grant: a lone requester wins; on contention the preferred requester wins.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = ALU_REQ_EXEC;
    if (req0_valid && req1_valid) begin
      grant_id = prio;
    end else if (req1_valid) begin
      grant_id = ALU_REQ_AUX;
    end
  end

  assign slot_free  = !rsp_valid || rsp_ready;
  assign accept     = grant_vld && slot_free;
  assign req0_ready = accept && (grant_id == ALU_REQ_EXEC);
  assign req1_ready = accept && (grant_id == ALU_REQ_AUX);

  // With no grant grant_id is EXEC, so the mux idles on requester 0.
  assign sel = (grant_id == ALU_REQ_AUX) ? r1 : r0;

  alu u_alu (
    .op_in        (sel.op),
    .sub_sra_in   (sel.sub_sra),
    .src1_in      (sel.src1),
    .src2_in      (sel.src2),
    .pc_in        (sel.pc),
    .rs1_in       (sel.rs1),
    .rs2_in       (sel.rs2),
    .imm_in       (sel.imm),
    .result_out   (alu_result),
    .non_zero_out (alu_non_zero)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign prio = ALU_REQ_EXEC;
`else
  // Round-robin pointer: after each accept, prefer the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= ALU_REQ_EXEC;
    end else if (accept) begin
      prio <= !grant_id;
    end
  end
`endif

  // Response register: load on accept, clear on drain, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_non_zero <= 1'b0;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= grant_id;
      rsp_result   <= alu_result;
      rsp_non_zero <= alu_non_zero;
    end else if (rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses, a monitor pops and compares.
// Latency: expects each response the cycle after its accept.
// Backpressure: exercises response stalls and simultaneous drain-and-accept.
module tb_alu_arbiter;
  import alu_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic        id;
    logic [63:0] res;
    logic        nz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub_sra;
  logic [4:0]  req0_op;
  logic [2:0]  req0_src1, req0_src2;
  logic [63:0] req0_pc, req0_rs1, req0_rs2, req0_imm;
  logic        req1_valid, req1_ready, req1_sub_sra;
  logic [4:0]  req1_op;
  logic [2:0]  req1_src1, req1_src2;
  logic [63:0] req1_pc, req1_rs1, req1_rs2, req1_imm;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_non_zero;
  logic [63:0] rsp_result;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [63:0] e0_res, e1_res;
  logic        e0_nz, e1_nz;

  logic        stall_prev = 1'b0;
  logic        h_id, h_nz, h_vld;
  logic [63:0] h_res;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_sub_sra(req0_sub_sra), .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req0_pc(req0_pc), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_sub_sra(req1_sub_sra), .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req1_pc(req1_pc), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_non_zero(rsp_non_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Load one requester's fields together with its hand-computed expected result.
  task automatic set_req(input int n, input logic [4:0] op, input logic sub,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic [63:0] pc, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] imm,
                         input logic [63:0] res, input logic nz);
    if (n == 0) begin
      req0_op = op; req0_sub_sra = sub; req0_src1 = s1; req0_src2 = s2;
      req0_pc = pc; req0_rs1 = rs1; req0_rs2 = rs2; req0_imm = imm;
      e0_res = res; e0_nz = nz;
    end else begin
      req1_op = op; req1_sub_sra = sub; req1_src1 = s1; req1_src2 = s2;
      req1_pc = pc; req1_rs1 = rs1; req1_rs2 = rs2; req1_imm = imm;
      e1_res = res; e1_nz = nz;
    end
  endtask

  // One clock: check readies against the expected grant (-1 = none), push the expected response.
  task automatic cycle(input int exp_id, input string tag);
    @(negedge clk);
    chk({tag, "_req0_ready"}, {63'd0, req0_ready}, {63'd0, exp_id == 0});
    chk({tag, "_req1_ready"}, {63'd0, req1_ready}, {63'd0, exp_id == 1});
    if (exp_id == 0) q.push_back('{id: 1'b0, res: e0_res, nz: e0_nz});
    if (exp_id == 1) q.push_back('{id: 1'b1, res: e1_res, nz: e1_nz});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each consumed response against the scoreboard; check hold while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid",  {63'd0, rsp_valid},    {63'd0, h_vld});
        chk("hold_id",     {63'd0, rsp_id},       {63'd0, h_id});
        chk("hold_result", rsp_result,            h_res);
        chk("hold_nz",     {63'd0, rsp_non_zero}, {63'd0, h_nz});
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d result %0h, expected no response", rsp_id, rsp_result);
        end else begin
          e = q.pop_front();
          chk("rsp_id",       {63'd0, rsp_id},       {63'd0, e.id});
          chk("rsp_result",   rsp_result,            e.res);
          chk("rsp_non_zero", {63'd0, rsp_non_zero}, {63'd0, e.nz});
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      h_vld = rsp_valid; h_id = rsp_id; h_res = rsp_result; h_nz = rsp_non_zero;
    end
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    set_req(0, ALU_OP_ADD_SUB, 1'b0, ALU_SRC1_REG, ALU_SRC2_REG, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    set_req(1, ALU_OP_ADD_SUB, 1'b0, ALU_SRC1_REG, ALU_SRC2_REG, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    #2;
    chk("reset_rsp_valid",  {63'd0, rsp_valid},    64'd0);
    chk("reset_rsp_id",     {63'd0, rsp_id},       64'd0);
    chk("reset_rsp_result", rsp_result,            64'd0);
    chk("reset_rsp_nz",     {63'd0, rsp_non_zero}, 64'd0);
    chk("reset_req0_ready", {63'd0, req0_ready},   64'd0);
    chk("reset_req1_ready", {63'd0, req1_ready},   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // ADD 5 + 7 from execute.
    set_req(0, ALU_OP_ADD_SUB, 1'b0, ALU_SRC1_REG, ALU_SRC2_REG, 64'd0, 64'd5, 64'd7, 64'd0, 64'd12, 1'b1);
    req0_valid = 1'b1;
    cycle(0, "add");
    req0_valid = 1'b0;
    chk("add_rsp_valid", {63'd0, rsp_valid}, 64'd1);

    // Aux alone: SLT -3 < 2.
    set_req(1, ALU_OP_SLT, 1'b0, ALU_SRC1_REG, ALU_SRC2_REG, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'd0, 64'd1, 1'b1);
    req1_valid = 1'b1;
    cycle(1, "slt");
    req1_valid = 1'b0;
    cycle(-1, "idle0");

    // Contention for 4 cycles: XOR FF^FF versus SUB 3-1.
    set_req(0, ALU_OP_XOR, 1'b0, ALU_SRC1_REG, ALU_SRC2_REG, 64'd0, 64'hFF, 64'hFF, 64'd0, 64'd0, 1'b0);
    set_req(1, ALU_OP_ADD_SUB, 1'b1, ALU_SRC1_REG, ALU_SRC2_REG, 64'd0, 64'd3, 64'd1, 64'd0, 64'd2, 1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle((FIXED || (i % 2 == 0)) ? 0 : 1, "rr");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle(-1, "idle1");

    // Stall: SLL 1<<4 stays pending while aux (PC+4) waits.
    rsp_ready = 1'b0;
    set_req(0, ALU_OP_SLL, 1'b0, ALU_SRC1_REG, ALU_SRC2_IMM, 64'd0, 64'd1, 64'd0, 64'd4, 64'd16, 1'b1);
    req0_valid = 1'b1;
    cycle(0, "sll");
    req0_valid = 1'b0;
    set_req(1, ALU_OP_ADD_SUB, 1'b0, ALU_SRC1_PC, ALU_SRC2_FOUR, 64'h1000, 64'd0, 64'd0, 64'd0, 64'h1004, 1'b1);
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle(-1, "stall");
    rsp_ready = 1'b1;
    cycle(1, "drain_accept");
    req1_valid = 1'b0;
    chk("drain_accept_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    cycle(-1, "idle2");

    // Aux alone with prio at exec, then contention shows prio back at exec.
    set_req(1, ALU_OP_SRL_SRA, 1'b1, ALU_SRC1_REG, ALU_SRC2_IMM, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 64'd4,
            64'hF800_0000_0000_0000, 1'b1);
    req1_valid = 1'b1;
    cycle(1, "sra");
    set_req(0, ALU_OP_AND, 1'b0, ALU_SRC1_REG, ALU_SRC2_REG, 64'd0, 64'hF0, 64'h3C, 64'd0, 64'h30, 1'b1);
    req0_valid = 1'b1;
    cycle(0, "and");
    req0_valid = 1'b0;
    cycle(1, "sra2");
    req1_valid = 1'b0;
    rsp_ready = 1'b0;

    // Asynchronous reset with a response pending.
    chk("pre_reset_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rsp_valid",  {63'd0, rsp_valid},    64'd0);
    chk("async_rsp_id",     {63'd0, rsp_id},       64'd0);
    chk("async_rsp_result", rsp_result,            64'd0);
    chk("async_rsp_nz",     {63'd0, rsp_non_zero}, 64'd0);
    chk("async_req0_ready", {63'd0, req0_ready},   64'd0);
    chk("async_req1_ready", {63'd0, req1_ready},   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // After reset prio is exec again: SLTU 0<5 wins over OR A0|0B.
    set_req(0, ALU_OP_SLTU, 1'b0, ALU_SRC1_ZERO, ALU_SRC2_REG, 64'd0, 64'd99, 64'd5, 64'd0, 64'd1, 1'b1);
    set_req(1, ALU_OP_OR, 1'b0, ALU_SRC1_REG, ALU_SRC2_REG, 64'd0, 64'hA0, 64'h0B, 64'd0, 64'hAB, 1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycle(0, "post_rst_sltu");
    req0_valid = 1'b0;
    cycle(1, "post_rst_or");
    req1_valid = 1'b0;

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
